// File: rtl/mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Data accesses win ties; one access is in flight at a time.
module mem_arbiter #(
  parameter int LATENCY = 4,
  parameter int AW      = 16,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  output logic          if_stall,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          dm_stall,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] LAST = 4'(LATENCY - 1);

  state_t        state;
  logic [3:0]    cnt;
  logic          grant_dm;
  logic          kill;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          wr_q;

  logic dm_req;
  logic resp;

  assign dm_req = dm_rd | dm_wr;
  assign resp   = (state == RESP) & ~rst;

  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          if (dm_req) begin
            mem_en    = 1'b1;
            mem_wr    = dm_wr;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
          end else if (if_req) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
          end
        end
        WAIT, RESP: begin
          mem_wr    = wr_q;
          mem_addr  = addr_q;
          mem_wdata = wdata_q;
        end
        default: ;
      endcase
    end
  end

  // A flushed fetch still occupies the memory but never reports done.
  assign dm_done  = resp & grant_dm;
  assign if_done  = resp & ~grant_dm & ~kill & ~if_flush;
  assign dm_rdata = dm_done ? mem_rdata : '0;
  assign if_rdata = if_done ? mem_rdata : '0;
  assign if_stall = if_req & ~if_done;
  assign dm_stall = dm_req & ~dm_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      grant_dm <= 1'b0;
      kill     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (dm_req | if_req) begin
            grant_dm <= dm_req;
            addr_q   <= dm_req ? dm_addr : if_addr;
            wdata_q  <= dm_req ? dm_wdata : '0;
            wr_q     <= dm_req & dm_wr;
            cnt      <= 4'd1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if (if_flush & ~grant_dm)
            kill <= 1'b1;
          if (cnt == LAST)
            state <= RESP;
        end
        RESP: begin
          kill  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle tables plus reset and latency-2 sequences.
// Memory model returns addr ^ 16'hA5B5 exactly LATENCY cycles after issue.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, dm_rd, dm_wr;
  logic [15:0] if_addr, dm_addr, dm_wdata;
  logic [15:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_done, if_stall, dm_done, dm_stall, mem_en, mem_wr;

  logic        if_req2;
  logic [15:0] if_addr2;
  logic [15:0] if_rdata2, dm_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic        if_done2, if_stall2, dm_done2, dm_stall2, mem_en2, mem_wr2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(4), .AW(16), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
    .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.LATENCY(2), .AW(16), .DW(16)) dut2 (
    .clk(clk), .rst(rst),
    .if_req(if_req2), .if_addr(if_addr2), .if_flush(1'b0),
    .if_rdata(if_rdata2), .if_done(if_done2), .if_stall(if_stall2),
    .dm_rd(1'b0), .dm_wr(1'b0), .dm_addr(16'h0), .dm_wdata(16'h0),
    .dm_rdata(dm_rdata2), .dm_done(dm_done2), .dm_stall(dm_stall2),
    .mem_en(mem_en2), .mem_wr(mem_wr2), .mem_addr(mem_addr2),
    .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2)
  );

  function automatic logic [15:0] memf(input logic [15:0] a);
    return a ^ 16'hA5B5;
  endfunction

  // memory models: countdown from issue, data valid only when it reaches 1
  int          cd, cd2;
  logic [15:0] la, la2;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cd  <= 0;
      cd2 <= 0;
    end else begin
      if (mem_en) begin
        cd <= 4;
        la <= mem_addr;
      end else if (cd != 0) cd <= cd - 1;
      if (mem_en2) begin
        cd2 <= 2;
        la2 <= mem_addr2;
      end else if (cd2 != 0) cd2 <= cd2 - 1;
    end
  end
  assign mem_rdata  = (cd == 1)  ? memf(la)  : 16'hDEAD;
  assign mem_rdata2 = (cd2 == 1) ? memf(la2) : 16'hDEAD;

  logic [69:0] outv;
  assign outv = {mem_en, mem_wr, mem_addr, mem_wdata, if_done, if_rdata,
                 dm_done, dm_rdata, if_stall, dm_stall};

  typedef struct {
    logic        ifr;
    logic [15:0] ifa;
    logic        fl;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dwd;
    logic [69:0] exp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input int n,
                     input logic ifr, input logic [15:0] ifa, input logic fl,
                     input logic dr, input logic dw, input logic [15:0] da,
                     input logic [15:0] dwd,
                     input logic en, input logic wr, input logic [15:0] ma,
                     input logic [15:0] mwd,
                     input logic ifd, input logic [15:0] ifrd,
                     input logic dmd, input logic [15:0] dmrd,
                     input logic ifs, input logic dms);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.fl = fl;
    v.dr = dr; v.dw = dw; v.da = da; v.dwd = dwd;
    v.exp = {en, wr, ma, mwd, ifd, ifrd, dmd, dmrd, ifs, dms};
    for (int k = 0; k < n; k++) tv.push_back(v);
  endtask

  task automatic chk(input string name, input logic [69:0] act,
                     input logic [69:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ifr, input logic [15:0] ifa,
                       input logic fl, input logic dr, input logic dw,
                       input logic [15:0] da, input logic [15:0] dwd);
    if_req = ifr; if_addr = ifa; if_flush = fl;
    dm_rd = dr; dm_wr = dw; dm_addr = da; dm_wdata = dwd;
  endtask

  int lat;

  initial begin
    rst = 1'b1;
    if_req2 = 1'b0;
    if_addr2 = '0;
    drive(1, 16'h10, 0, 1, 0, 16'h200, 16'h0);

    // lone fetch
    add(1, 1,'h10,0, 0,0,0,0, 1,0,'h10,0, 0,0, 0,0, 1,0);
    add(3, 1,'h10,0, 0,0,0,0, 0,0,'h10,0, 0,0, 0,0, 1,0);
    add(1, 1,'h10,0, 0,0,0,0, 0,0,'h10,0, 1,'hA5A5, 0,0, 0,0);
    add(1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0);
    // simultaneous: DM first, then IF; flush during DM is ignored
    add(1, 1,'h20,0, 1,0,'h200,0, 1,0,'h200,0, 0,0, 0,0, 1,1);
    add(1, 1,'h20,0, 1,0,'h200,0, 0,0,'h200,0, 0,0, 0,0, 1,1);
    add(1, 1,'h20,1, 1,0,'h200,0, 0,0,'h200,0, 0,0, 0,0, 1,1);
    add(1, 1,'h20,0, 1,0,'h200,0, 0,0,'h200,0, 0,0, 0,0, 1,1);
    add(1, 1,'h20,0, 1,0,'h200,0, 0,0,'h200,0, 0,0, 1,'hA7B5, 1,0);
    add(1, 1,'h20,0, 0,0,0,0, 1,0,'h20,0, 0,0, 0,0, 1,0);
    add(3, 1,'h20,0, 0,0,0,0, 0,0,'h20,0, 0,0, 0,0, 1,0);
    add(1, 1,'h20,0, 0,0,0,0, 0,0,'h20,0, 1,'hA595, 0,0, 0,0);
    add(1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0);
    // write wins over read; inputs changing mid-access are ignored
    add(1, 0,0,0, 1,1,'h300,'h1234, 1,1,'h300,'h1234, 0,0, 0,0, 0,1);
    add(1, 0,0,0, 1,1,'h300,'h1234, 0,1,'h300,'h1234, 0,0, 0,0, 0,1);
    add(1, 0,0,0, 1,1,'hFFF,'hFFFF, 0,1,'h300,'h1234, 0,0, 0,0, 0,1);
    add(1, 0,0,0, 1,1,'h300,'h1234, 0,1,'h300,'h1234, 0,0, 0,0, 0,1);
    add(1, 0,0,0, 1,1,'h300,'h1234, 0,1,'h300,'h1234, 0,0, 1,'hA6B5, 0,0);
    add(1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0);
    // flushed fetch, then redirected fetch
    add(1, 1,'h30,0, 0,0,0,0, 1,0,'h30,0, 0,0, 0,0, 1,0);
    add(1, 1,'h30,0, 0,0,0,0, 0,0,'h30,0, 0,0, 0,0, 1,0);
    add(1, 1,'h40,1, 0,0,0,0, 0,0,'h30,0, 0,0, 0,0, 1,0);
    add(2, 1,'h40,0, 0,0,0,0, 0,0,'h30,0, 0,0, 0,0, 1,0);
    add(1, 1,'h40,0, 0,0,0,0, 1,0,'h40,0, 0,0, 0,0, 1,0);
    add(3, 1,'h40,0, 0,0,0,0, 0,0,'h40,0, 0,0, 0,0, 1,0);
    add(1, 1,'h40,0, 0,0,0,0, 0,0,'h40,0, 1,'hA5F5, 0,0, 0,0);
    add(1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0);
    // flush in IDLE does not affect the fetch it coincides with
    add(1, 1,'h50,1, 0,0,0,0, 1,0,'h50,0, 0,0, 0,0, 1,0);
    add(3, 1,'h50,0, 0,0,0,0, 0,0,'h50,0, 0,0, 0,0, 1,0);
    add(1, 1,'h50,0, 0,0,0,0, 0,0,'h50,0, 1,'hA5E5, 0,0, 0,0);
    add(1, 0,0,0, 0,0,0,0, 0,0,0,0, 0,0, 0,0, 0,0);

    repeat (2) @(negedge clk);
    chk("reset_outputs", outv, {68'h0, 2'b11});
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", outv, 70'h0);

    for (int i = 0; i < tv.size(); i++) begin
      @(posedge clk); #1;
      drive(tv[i].ifr, tv[i].ifa, tv[i].fl, tv[i].dr, tv[i].dw,
            tv[i].da, tv[i].dwd);
      @(negedge clk);
      chk($sformatf("row%0d", i), outv, tv[i].exp);
    end

    // reset in the middle of a data access
    @(posedge clk); #1;
    drive(0, 0, 0, 1, 0, 16'h400, 16'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid_zero", outv, {68'h0, 2'b01});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rst_no_done%0d", k), {69'h0, dm_done}, 70'h0);
    end
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("reissue_en", {68'h0, mem_en, mem_wr}, {68'h0, 2'b10});
    chk("reissue_addr", {54'h0, mem_addr}, {54'h0, 16'h400});
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (dm_done) begin
        lat = k;
        break;
      end
    end
    chk("reissue_latency", 70'(lat), 70'd4);
    chk("reissue_rdata", {54'h0, dm_rdata}, {54'h0, 16'hA1B5});
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // LATENCY=2 back-to-back fetches
    for (int c = 0; c < 9; c++) begin
      @(posedge clk); #1;
      if_req2 = 1'b1;
      if_addr2 = 16'h100 + 16'(4 * (c / 3));
      @(negedge clk);
      chk($sformatf("lat2_c%0d", c), {52'h0, mem_en2, if_done2, if_rdata2},
          {52'h0, (c % 3) == 0, (c % 3) == 2,
           ((c % 3) == 2) ? memf(if_addr2) : 16'h0});
    end
    @(posedge clk); #1 if_req2 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-port, fixed-latency unified memory between the IF-stage instruction fetch and the MEM-stage data access of the pipelined processor. It issues one access at a time, holds the winning address and data stable while the access is in flight, and returns read data with a one-cycle done pulse. It generates the per-stage stall signals that the pipeline ORs with the hazard-detection stall. Data accesses have priority because they belong to the older instruction.

## Interface
Parameters:
- LATENCY, 4, cycles from issue to valid mem_rdata; legal range 2..15
- AW, 16, address width
- DW, 16, data width

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, level, held until if_done
- if_addr  in  AW  fetch address
- if_flush  in  1  branch/jump redirect: discard the in-flight fetch result
- if_rdata  out  DW  instruction, valid only while if_done
- if_done  out  1  fetch complete, one-cycle pulse
- if_stall  out  1  fetch stage must hold
- dm_rd, dm_wr  in  1 each  data read/write request, level, held until dm_done
- dm_addr  in  AW  data address
- dm_wdata  in  DW  store data
- dm_rdata  out  DW  load data, valid only while dm_done
- dm_done  out  1  data access complete, one-cycle pulse
- dm_stall  out  1  MEM stage and everything upstream must hold
- mem_en  out  1  one-cycle issue strobe to memory
- mem_wr  out  1  write enable, valid with mem_en
- mem_addr  out  AW  address, held from issue through response
- mem_wdata  out  DW  write data, held from issue through response
- mem_rdata  in  DW  read data, valid exactly LATENCY cycles after the mem_en cycle

## Operation
- dm_req = dm_rd | dm_wr. If both are high, the access is a write.
- FSM states: IDLE, WAIT, RESP.
  - IDLE:
    - If dm_req: issue the data access.
    - Else if if_req: issue the fetch.
    - Else stay in IDLE.
    - Issue means mem_en=1 combinationally in that cycle. mem_addr, mem_wdata and mem_wr come from the winning inputs.
    - At the issue edge, latch grant (IF or DM), address, wdata and wr; load cnt=1; go to WAIT.
  - WAIT: cnt increments each cycle. When cnt==LATENCY-1, go to RESP.
  - RESP: go to IDLE unconditionally.
- mem_addr, mem_wdata and mem_wr are driven from the latched registers in WAIT and RESP. They are 0 in IDLE when no request is present.
- Done outputs:
  - dm_done = (state==RESP) & grant==DM.
  - if_done = (state==RESP) & grant==IF & ~kill & ~if_flush.
- rdata outputs:
  - dm_rdata = mem_rdata while dm_done, else 0.
  - if_rdata = mem_rdata while if_done, else 0.
- Stall outputs: if_stall = if_req & ~if_done; dm_stall = dm_req & ~dm_done.
- Flush:
  - kill is set when if_flush is sampled high while grant==IF in WAIT. It clears on the RESP to IDLE transition.
  - A killed fetch still completes on the memory side, because the memory cannot be aborted, but it produces no if_done.
  - The requester keeps if_req high with the redirected address. That fetch is issued from IDLE like any new request.
  - if_flush in IDLE or during a DM access has no effect.
- Request inputs are sampled only in IDLE. Address or data changes during WAIT/RESP are ignored.
- A write returns dm_done with dm_rdata=mem_rdata, which the pipeline ignores.

## Timing
- Reset values (async):
  - state=IDLE, cnt=0, grant=IF, kill=0, latched addr/wdata/wr=0.
  - While rst is high, mem_en, mem_wr, if_done and dm_done are forced 0.
- Issue to done: issue in cycle T, done in cycle T+LATENCY.
- Throughput: one access per LATENCY+1 cycles. The earliest re-issue is the cycle after RESP.
- Requesters advance on the edge that ends the done cycle, so the requests seen in the next IDLE cycle are new.
- Simultaneous requests in IDLE: DM wins. IF issues in the IDLE cycle after the DM RESP unless another dm_req is present.
- Reset mid-access abandons the access: no done pulse, the FSM is in IDLE after rst deasserts.
- cnt width is 4 bits and never wraps within the legal LATENCY range.

## Test plan
- Lone fetch, LATENCY=4, if_addr=0x0010, mem_rdata=0xA5A5 at T+4 -> mem_en only at T; if_done and if_rdata=0xA5A5 only at T+4; if_stall high T..T+3.
- if_req and dm_rd together at T, dm_addr=0x0200 -> DM issued at T, dm_done at T+4; IF mem_en at T+5 with if_addr, if_done at T+9.
- dm_wr=1 with dm_rd=1, dm_wdata=0x1234 -> mem_wr=1 at issue; mem_addr/mem_wdata held stable T..T+4; dm_done at T+4.
- Fetch issued at T, if_flush at T+2, if_addr changed to 0x0040 -> no if_done at T+4; new mem_en at T+5 with addr 0x0040; if_done at T+9.
- rst asserted at T+2 of a DM access -> outputs zero immediately; no dm_done; after release, a pending dm_req is re-issued from IDLE on the first clock.
- LATENCY=2, back-to-back fetches -> mem_en every 3 cycles, if_done 2 cycles after each issue.
